// File: rtl/bcd_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : bcd_serial_subtractor
// Purpose  : Digit-serial packed-BCD subtractor, DIFF = A - B, one digit per
//            clock, least-significant digit first, start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_serial_subtractor #(
    parameter int NDIG = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [4*NDIG-1:0] a_i,
    input  logic [4*NDIG-1:0] b_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [4*NDIG-1:0] diff_o,
    output logic              borrow_o,
    output logic              invalid_o
);

    localparam int W  = 4 * NDIG;
    localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NDIG - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    diff_q;
    logic [CW-1:0]   cnt_q;
    logic            brw_q;
    logic            borrow_q;
    logic            invalid_q;
    logic            done_q;
    logic            busy_q;

    logic            bad_digit;
    logic signed [4:0] sub_t;
    logic [3:0]      dig_d;
    logic            brw_d;
    logic [W-1:0]    diff_sh;
    logic [W-1:0]    a_sh;
    logic [W-1:0]    b_sh;

    always_comb begin
        bad_digit = 1'b0;
        for (int k = 0; k < NDIG; k++) begin
            if ((a_i[4*k +: 4] > 4'd9) || (b_i[4*k +: 4] > 4'd9)) begin
                bad_digit = 1'b1;
            end
        end
    end

    // Negative partial difference wraps back into 0..9 by adding ten.
    always_comb begin
        sub_t = $signed({1'b0, a_q[3:0]}) - $signed({1'b0, b_q[3:0]})
              - $signed({4'b0000, brw_q});
        brw_d = sub_t[4];
        dig_d = brw_d ? (sub_t[3:0] + 4'd10) : sub_t[3:0];
    end

    // Result digits enter at the top so digit 0 lands at [3:0] after NDIG steps.
    if (NDIG > 1) begin : g_multi
        assign diff_sh = {dig_d, diff_q[W-1:4]};
        assign a_sh    = {4'd0, a_q[W-1:4]};
        assign b_sh    = {4'd0, b_q[W-1:4]};
    end else begin : g_single
        assign diff_sh = dig_d;
        assign a_sh    = '0;
        assign b_sh    = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            diff_q    <= '0;
            cnt_q     <= '0;
            brw_q     <= 1'b0;
            borrow_q  <= 1'b0;
            invalid_q <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        a_q       <= a_i;
                        b_q       <= b_i;
                        diff_q    <= '0;
                        borrow_q  <= 1'b0;
                        invalid_q <= bad_digit;
                        cnt_q     <= '0;
                        brw_q     <= 1'b0;
                        if (bad_digit) begin
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    diff_q <= diff_sh;
                    a_q    <= a_sh;
                    b_q    <= b_sh;
                    brw_q  <= brw_d;
                    if (cnt_q == CNT_LAST) begin
                        borrow_q <= brw_d;
                        busy_q   <= 1'b0;
                        state_q  <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign diff_o    = diff_q;
    assign borrow_o  = borrow_q;
    assign invalid_o = invalid_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_serial_subtractor
// Purpose  : Directed bench for bcd_serial_subtractor with a decimal-arithmetic
//            reference model and a per-cycle output comparator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_serial_subtractor;

    localparam int NDIG = 4;
    localparam int W    = 4 * NDIG;

    logic         clk     = 1'b0;
    logic         rst_n   = 1'b0;
    logic         start_i = 1'b0;
    logic [W-1:0] a_i     = '0;
    logic [W-1:0] b_i     = '0;
    logic         busy_o;
    logic         done_o;
    logic [W-1:0] diff_o;
    logic         borrow_o;
    logic         invalid_o;

    int errors = 0;
    int checks = 0;

    bcd_serial_subtractor #(.NDIG(NDIG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start_i),
        .a_i       (a_i),
        .b_i       (b_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .diff_o    (diff_o),
        .borrow_o  (borrow_o),
        .invalid_o (invalid_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int bcd2int(input logic [W-1:0] v);
        int r = 0;
        for (int k = NDIG - 1; k >= 0; k--) r = r * 10 + int'(v[4*k +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int x);
        logic [W-1:0] r = '0;
        int y = x;
        for (int k = 0; k < NDIG; k++) begin
            r[4*k +: 4] = 4'(y % 10);
            y = y / 10;
        end
        return r;
    endfunction

    function automatic bit has_bad(input logic [W-1:0] v);
        bit r = 0;
        for (int k = 0; k < NDIG; k++) if (v[4*k +: 4] > 4'd9) r = 1;
        return r;
    endfunction

    // Reference model: decimal result computed at acceptance, timing by phase count.
    bit           m_active = 0;
    bit           m_show   = 1;
    int           m_phase  = 0;
    int           m_lat    = 0;
    logic [W-1:0] m_diff   = '0;
    bit           m_borrow = 0;
    bit           m_inv    = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0;
            m_show   = 1;
            m_diff   = '0;
            m_borrow = 0;
            m_inv    = 0;
        end else if ((!m_active || m_phase == m_lat) && start_i) begin
            int pw;
            int d;
            pw = 1;
            for (int k = 0; k < NDIG; k++) pw = pw * 10;
            m_active = 1;
            m_phase  = 0;
            m_show   = 0;
            m_inv    = has_bad(a_i) || has_bad(b_i);
            if (m_inv) begin
                m_diff   = '0;
                m_borrow = 0;
                m_lat    = 1;
            end else begin
                d        = bcd2int(a_i) - bcd2int(b_i);
                m_borrow = (d < 0);
                if (d < 0) d = d + pw;
                m_diff   = int2bcd(d);
                m_lat    = NDIG + 1;
            end
        end else if (m_active) begin
            m_phase++;
            if (m_phase == m_lat) m_show = 1;
            if (m_phase > m_lat) m_active = 0;
        end
    end

    always @(negedge clk) begin
        chk("busy", busy_o, (m_active && m_lat == NDIG + 1 && m_phase < NDIG));
        chk("done", done_o, (m_active && m_phase == m_lat));
        if (m_show) begin
            chk("diff", diff_o, m_diff);
            chk("borrow", borrow_o, m_borrow);
            chk("invalid", invalid_o, m_inv);
        end
    end

    task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ed, input bit eb, input bit ei, input int elat);
        int lat;
        @(negedge clk);
        a_i     = a;
        b_i     = b;
        start_i = 1'b1;
        lat     = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (done_o) begin
                lat = n;
                break;
            end
        end
        chk({nm, " latency"}, lat, elat);
        chk({nm, " diff"}, diff_o, ed);
        chk({nm, " borrow"}, borrow_o, eb);
        chk({nm, " invalid"}, invalid_o, ei);
    endtask

    initial begin
        int ndone;
        int lat;
        int lat2;
        logic [W-1:0] got_d;
        logic got_b;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("reset busy", busy_o, 0);
        chk("reset done", done_o, 0);
        chk("reset diff", diff_o, 0);
        chk("reset borrow", borrow_o, 0);
        chk("reset invalid", invalid_o, 0);

        run_op("v1234m0567", 16'h1234, 16'h0567, 16'h0667, 0, 0, 5);
        run_op("v0000m0001", 16'h0000, 16'h0001, 16'h9999, 1, 0, 5);
        run_op("v9999m9999", 16'h9999, 16'h9999, 16'h0000, 0, 0, 5);
        run_op("v12A4inv",   16'h12A4, 16'h0001, 16'h0000, 0, 1, 1);
        run_op("v5000m0001", 16'h5000, 16'h0001, 16'h4999, 0, 0, 5);
        run_op("v0805m0190", 16'h0805, 16'h0190, 16'h0615, 0, 0, 5);
        run_op("vbinv",      16'h0001, 16'h000F, 16'h0000, 0, 1, 1);

        // Second start two cycles into RUN must be ignored.
        @(negedge clk);
        a_i = 16'h1234; b_i = 16'h0567; start_i = 1'b1;
        ndone = 0; lat = -1; got_d = '0; got_b = 1'b1;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (n == 0) start_i = 1'b0;
            if (n == 1) begin start_i = 1'b1; a_i = 16'h9999; b_i = 16'h1111; end
            if (n == 2) start_i = 1'b0;
            if (done_o) begin
                ndone++;
                if (lat < 0) begin lat = n; got_d = diff_o; got_b = borrow_o; end
            end
        end
        chk("ignore done count", ndone, 1);
        chk("ignore latency", lat, 5);
        chk("ignore diff", got_d, 16'h0667);
        chk("ignore borrow", got_b, 0);

        // Back-to-back: start held high across DONE into IDLE.
        @(negedge clk);
        a_i = 16'h5000; b_i = 16'h0001; start_i = 1'b1;
        lat = -1; lat2 = -1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (done_o && lat < 0) begin
                lat = n;
                chk("b2b first diff", diff_o, 16'h4999);
                a_i = 16'h0100; b_i = 16'h0200;
            end else if (done_o) begin
                lat2 = n;
                break;
            end
            if (n == lat + 1 && lat >= 0) start_i = 1'b0;
        end
        start_i = 1'b0;
        chk("b2b first latency", lat, 5);
        chk("b2b second latency", lat2, 11);
        chk("b2b second diff", diff_o, 16'h9900);
        chk("b2b second borrow", borrow_o, 1);

        // Reset during the second RUN cycle aborts the operation.
        @(negedge clk);
        a_i = 16'h1234; b_i = 16'h0567; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort busy", busy_o, 0);
        chk("abort done", done_o, 0);
        chk("abort diff", diff_o, 0);
        chk("abort borrow", borrow_o, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        ndone = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (done_o) ndone++;
        end
        chk("abort no done", ndone, 0);
        run_op("after abort", 16'h0100, 16'h0200, 16'h9900, 1, 0, 5);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
